nibble_packer: RTL and testbench
================================

NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in bytes; power of two, 2..16.
REQ-002 Parameter PAD, default 4'h0, upper nibble used when a flush completes a half byte.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 nib_vld  input  1  nib is valid this cycle; no backpressure to the producer.
REQ-006 nib  input  4  nibble from the upstream registered 4-bit output stage.
REQ-007 flush  input  1  pads and pushes any held half byte.
REQ-008 byte_vld  output  1  FIFO head valid.
REQ-009 byte_data  output  8  FIFO head byte.
REQ-010 byte_rdy  input  1  consumer accepts head when byte_vld=1.
REQ-011 full  output  1  level==DEPTH.
REQ-012 level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 ovf_clr  input  1  clears ovf.
REQ-015 byte_par  output  1  even parity of byte_data; present only with NIBPACK_PARITY_EN.

Function
REQ-016 Pack FSM has two states, IDLE (no nibble held) and HALF (low nibble held in a 4-bit hold register).
REQ-017 IDLE, nib_vld=1, flush=0: hold<=nib, go to HALF, no push.
REQ-018 IDLE, nib_vld=1, flush=1: push {PAD,nib}, stay in IDLE.
REQ-019 IDLE, nib_vld=0: flush has no effect.
REQ-020 HALF, nib_vld=1: push {nib,hold}, go to IDLE; flush is ignored that cycle.
REQ-021 HALF, nib_vld=0, flush=1: push {PAD,hold}, go to IDLE.
REQ-022 HALF, nib_vld=0, flush=0: hold state.
REQ-023 A push is accepted when level<DEPTH or a pop happens in the same cycle (byte_vld&byte_rdy).
REQ-024 A rejected push drops the byte and sets ovf; the FSM still takes its normal transition.
REQ-025 A pop occurs on byte_vld&byte_rdy; byte_rdy is ignored when level==0.
REQ-026 A simultaneous accepted push and pop leaves level unchanged.
REQ-027 Read and write pointers wrap modulo DEPTH.
REQ-028 byte_vld=(level!=0); byte_data is read combinationally from the registered head entry.
REQ-029 Latency: a byte pushed in cycle N into an empty FIFO appears with byte_vld=1 in cycle N+1.
REQ-030 ovf holds until a cycle with ovf_clr=1; if set and clear coincide, set wins.

Reset
REQ-031 When rst=1, asynchronously: FSM=IDLE, hold=0, pointers=0, level=0, byte_vld=0, full=0, ovf=0, byte_par=0.
REQ-032 byte_data SHALL read 8'h00 while level==0 after reset.
REQ-033 rst asserted mid-operation discards the held nibble and all FIFO contents, with no push or pop that cycle.

Configuration
REQ-034 With NIBPACK_PARITY_EN defined:
- each FIFO entry is 9 bits wide: byte plus even parity computed at push;
- byte_par outputs the head entry's parity bit.
REQ-035 Without NIBPACK_PARITY_EN:
- FIFO entries are 8 bits wide;
- byte_par port and parity logic are absent.

Verification
REQ-036 Sequence: nib 4'h3 then 4'hA, consumer ready -> byte_data=8'hA3 with byte_vld=1 one cycle after the second nibble; level returns to 0.
REQ-037 nib 4'h5, idle 2 cycles, then flush -> byte 8'h05 pushed (PAD=0); FSM back in IDLE.
REQ-038 DEPTH=4, byte_rdy=0, 10 nibbles:
- bytes 1-4 are stored and full=1;
- byte 5 is dropped and ovf=1;
- pop order is the first four bytes.
REQ-039 With the FIFO full, push and byte_rdy=1 in the same cycle -> push accepted, level stays 4, ovf stays 0.
REQ-040 rst pulse while in HALF with level=2 -> level=0 and byte_vld=0 immediately; the next nibble 4'h1 is treated as a low nibble.
REQ-041 NIBPACK_PARITY_EN defined, pack 8'h07 -> byte_par=1; pack 8'h03 -> byte_par=0.

Source files
------------

// File: rtl/nibble_packer.sv
// nibble_packer: packs nibbles into bytes through a small FIFO; NIBPACK_PARITY_EN adds byte_par
module nibble_packer #(
  parameter int         DEPTH = 4,
  parameter logic [3:0] PAD   = 4'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     nib_vld,
  input  logic [3:0]               nib,
  input  logic                     flush,
  output logic                     byte_vld,
  output logic [7:0]               byte_data,
  input  logic                     byte_rdy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
`ifdef NIBPACK_PARITY_EN
  output logic                     byte_par,
`endif
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef NIBPACK_PARITY_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif
  typedef enum logic {IDLE, HALF} state_t;
  state_t state, state_nx;
  logic [3:0] hold;
  logic push, hold_ld, pop, push_ok;
  logic [7:0] push_byte;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_ent, head;
  logic [AW-1:0] wptr, rptr;
  // pack state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // pack next state: a flush or a second nibble always returns to IDLE
  always_comb
    state_nx = (state == IDLE) ? ((nib_vld & ~flush) ? HALF : IDLE)
                               : ((nib_vld | flush) ? IDLE : HALF);
  // pack outputs: push request, byte to push and hold-register load
  always_comb begin
    push      = nib_vld ? (state == HALF || flush) : (state == HALF && flush);
    hold_ld   = state == IDLE && nib_vld && !flush;
    push_byte = (state == HALF) ? {nib_vld ? nib : PAD, hold} : {PAD, nib};
  end
  // low nibble waiting for its partner
  always_ff @(posedge clk or posedge rst)
    if (rst) hold <= 4'h0;
    else if (hold_ld) hold <= nib;
  assign byte_vld = level != '0;
  assign full     = level == LW'(DEPTH);
  assign pop      = byte_vld & byte_rdy;
  assign push_ok  = push & (~full | pop);
`ifdef NIBPACK_PARITY_EN
  assign wr_ent   = {^push_byte, push_byte};
  assign byte_par = byte_vld & head[8];
`else
  assign wr_ent   = push_byte;
`endif
  assign head      = mem[rptr];
  assign byte_data = byte_vld ? head[7:0] : 8'h00;
  // storage array; contents are only observed through byte_vld-masked outputs
  always_ff @(posedge clk)
    if (push_ok && !rst) mem[wptr] <= wr_ent;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + LW'(push_ok) - LW'(pop);
    end
  // sticky overflow; a new drop outranks a clear in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (push & ~push_ok) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed checks of packing, flush, FIFO full/overflow and reset
module tb_nibble_packer;
  logic clk = 1'b0, rst = 1'b1, nib_vld = 1'b0, flush = 1'b0, byte_rdy = 1'b0, ovf_clr = 1'b0;
  logic [3:0] nib = 4'h0;
  logic byte_vld, full, ovf;
  logic [7:0] byte_data;
  logic [2:0] level;
`ifdef NIBPACK_PARITY_EN
  logic byte_par;
`endif
  int vec = 0, errs = 0;
  logic [7:0] exp_c [4] = '{8'h21, 8'h43, 8'h65, 8'h87};

  nibble_packer #(.DEPTH(4), .PAD(4'h0)) dut (
    .clk(clk), .rst(rst), .nib_vld(nib_vld), .nib(nib), .flush(flush),
    .byte_vld(byte_vld), .byte_data(byte_data), .byte_rdy(byte_rdy),
    .full(full), .level(level), .ovf(ovf),
`ifdef NIBPACK_PARITY_EN
    .byte_par(byte_par),
`endif
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1;
    chk("rst_level", 8'(level), 8'h0);
    chk("rst_vld", 8'(byte_vld), 8'h0);
    chk("rst_full", 8'(full), 8'h0);
    chk("rst_ovf", 8'(ovf), 8'h0);
    chk("rst_data", byte_data, 8'h00);
`ifdef NIBPACK_PARITY_EN
    chk("rst_par", 8'(byte_par), 8'h0);
`endif
    cyc();
    cyc();
    rst = 1'b0;
    // basic pair 3,A with consumer ready
    byte_rdy = 1'b1; nib_vld = 1'b1; nib = 4'h3;
    cyc();
    chk("a_lo_level", 8'(level), 8'h0);
    chk("a_lo_vld", 8'(byte_vld), 8'h0);
    nib = 4'hA;
    cyc();
    chk("a_vld", 8'(byte_vld), 8'h1);
    chk("a_data", byte_data, 8'hA3);
    nib_vld = 1'b0;
    cyc();
    chk("a_drain", 8'(level), 8'h0);
    chk("a_drain_data", byte_data, 8'h00);
    // half byte then flush after two idle cycles
    byte_rdy = 1'b0; nib_vld = 1'b1; nib = 4'h5;
    cyc();
    nib_vld = 1'b0;
    cyc();
    cyc();
    chk("b_idle_level", 8'(level), 8'h0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("b_flush_level", 8'(level), 8'h1);
    chk("b_flush_data", byte_data, 8'h05);
    byte_rdy = 1'b1;
    cyc();
    byte_rdy = 1'b0; nib_vld = 1'b1; nib = 4'h7;
    cyc();
    chk("b_idle_lo", 8'(level), 8'h0);
    nib = 4'h8;
    cyc();
    chk("b_after_flush", byte_data, 8'h87);
    nib_vld = 1'b0; byte_rdy = 1'b1;
    cyc();
    // flush alone in IDLE does nothing
    byte_rdy = 1'b0; flush = 1'b1;
    cyc();
    chk("idle_flush", 8'(level), 8'h0);
    // nibble plus flush in IDLE pushes a padded byte
    nib_vld = 1'b1; nib = 4'h9;
    cyc();
    chk("idle_nib_flush", byte_data, 8'h09);
    nib_vld = 1'b0; flush = 1'b0; byte_rdy = 1'b1;
    cyc();
    // flush ignored when the high nibble arrives
    byte_rdy = 1'b0; nib_vld = 1'b1; nib = 4'h1;
    cyc();
    nib = 4'h2; flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("half_flush_ign", byte_data, 8'h21);
    chk("half_flush_lvl", 8'(level), 8'h1);
    nib_vld = 1'b0; byte_rdy = 1'b1;
    cyc();
    // overflow: ten nibbles, no consumer
    byte_rdy = 1'b0; nib_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nib = 4'(i + 1);
      cyc();
    end
    chk("c_full", 8'(full), 8'h1);
    chk("c_ovf0", 8'(ovf), 8'h0);
    nib = 4'h9;
    cyc();
    nib = 4'hA;
    cyc();
    nib_vld = 1'b0;
    chk("c_ovf1", 8'(ovf), 8'h1);
    chk("c_level", 8'(level), 8'h4);
    byte_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("c_pop", byte_data, exp_c[i]);
      cyc();
    end
    byte_rdy = 1'b0;
    chk("c_empty", 8'(level), 8'h0);
    chk("c_sticky", 8'(ovf), 8'h1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("c_clr", 8'(ovf), 8'h0);
    // push while full with a simultaneous pop
    nib_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nib = 4'(i);
      cyc();
    end
    nib = 4'h8;
    cyc();
    nib = 4'h9; byte_rdy = 1'b1;
    cyc();
    byte_rdy = 1'b0;
    chk("d_level", 8'(level), 8'h4);
    chk("d_ovf", 8'(ovf), 8'h0);
    chk("d_head", byte_data, 8'h32);
    // overflow and clear in the same cycle: set wins
    nib = 4'hB;
    cyc();
    nib = 4'hC; ovf_clr = 1'b1;
    cyc();
    nib_vld = 1'b0;
    chk("d_set_wins", 8'(ovf), 8'h1);
    cyc();
    ovf_clr = 1'b0;
    chk("d_clr", 8'(ovf), 8'h0);
    // reset while HALF with two bytes stored
    byte_rdy = 1'b1;
    cyc();
    cyc();
    byte_rdy = 1'b0; nib_vld = 1'b1; nib = 4'h5;
    cyc();
    nib_vld = 1'b0;
    chk("e_pre_level", 8'(level), 8'h2);
    rst = 1'b1;
    #1;
    chk("e_rst_level", 8'(level), 8'h0);
    chk("e_rst_vld", 8'(byte_vld), 8'h0);
    cyc();
    rst = 1'b0; nib_vld = 1'b1; nib = 4'h1;
    cyc();
    chk("e_lo_level", 8'(level), 8'h0);
    nib = 4'hF;
    cyc();
    nib_vld = 1'b0;
    chk("e_byte", byte_data, 8'hF1);
    byte_rdy = 1'b1;
    cyc();
    byte_rdy = 1'b0;
`ifdef NIBPACK_PARITY_EN
    nib_vld = 1'b1; nib = 4'h7;
    cyc();
    nib = 4'h0;
    cyc();
    nib_vld = 1'b0;
    chk("p_07", 8'(byte_par), 8'h1);
    byte_rdy = 1'b1;
    cyc();
    byte_rdy = 1'b0; nib_vld = 1'b1; nib = 4'h3;
    cyc();
    nib = 4'h0;
    cyc();
    nib_vld = 1'b0;
    chk("p_03", 8'(byte_par), 8'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
